operand_fetch_decoder: RTL
==========================

# operand_fetch_decoder

Parametrised operand fetch decoder for the crypto datapath. It accepts an operand code over a valid/ready handshake and splits it into a bank select and a word address. It then issues the read to one of `NUM_BANKS` synchronous memories, such as key-value and state-variable stores, and waits a configurable memory latency. The selected word is returned over an output valid/ready handshake, so it can sit between the instruction sequencer and the arithmetic units.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of each memory word and of `out_value`.
- `CODE_WIDTH`, 8: width of `inp_code`.
- `ADDR_WIDTH`, 4: memory address width; `mem_addr = inp_code[ADDR_WIDTH-1:0]`.
- `NUM_BANKS`, 3: number of source memories, minimum 1.
- `SEL_WIDTH`, `$clog2(NUM_BANKS)` with a minimum of 1: bank field width; `bank = inp_code[CODE_WIDTH-1 -: SEL_WIDTH]`.
- Constraint: `SEL_WIDTH + ADDR_WIDTH <= CODE_WIDTH`.
- `MEM_DELAY`, 2: memory read latency in cycles, minimum 1.

Ports:
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `code_valid`, in, 1: `inp_code` is valid.
- `code_ready`, out, 1: decoder can accept a code.
- `inp_code`, in, `CODE_WIDTH`: operand code.
- `mem_addr`, out, `ADDR_WIDTH`: registered read address, shared by all banks.
- `mem_rd_en`, out, `NUM_BANKS`: one-hot read strobe, pulsed for one cycle.
- `mem_data_out`, in, `NUM_BANKS*DATA_WIDTH`: bank *b* is at `[b*DATA_WIDTH +: DATA_WIDTH]`.
- `out_valid`, out, 1: `out_value` is valid.
- `out_ready`, in, 1: consumer accepts `out_value`.
- `out_value`, out, `DATA_WIDTH`: fetched word.
- `out_error`, out, 1: bank field out of range. Present only with the macro in Configuration.
- `busy`, out, 1: high whenever the state is not `IDLE`.

## Operation
State machine:
- **IDLE**
  - `code_ready = 1`.
  - On `code_valid`: register `mem_addr`, register `bank`, pulse `mem_rd_en[bank]`, load `counter = MEM_DELAY-1`, go to WAIT.
- **WAIT**
  - If `counter != 0`: decrement `counter`.
  - If `counter == 0`: latch the selected bank slice of `mem_data_out` into `out_value`, set `out_valid = 1`, go to OUT.
- **OUT**
  - Hold `out_value`, `out_valid` and `mem_addr` stable.
  - On `out_ready`: clear `out_valid`, go to IDLE.
- **Unreachable encodings:** return to IDLE with `out_valid` cleared.

Other rules:
- `code_ready` and `busy` are decoded combinationally from the state only; `code_ready = (state == IDLE)`.
- The bank and address fields are captured at accept. Later changes on `inp_code` have no effect.
- `mem_rd_en` is a single-cycle pulse. A bank index `>= NUM_BANKS` drives no strobe.
- Reset values:
  - state = IDLE, `counter = 0`.
  - `mem_addr = 0`, `mem_rd_en = 0`.
  - `out_valid = 0`, `out_value = 0`, `out_error = 0`.
- Reset mid-operation: any in-flight fetch is dropped and no output is produced.

## Timing
- **Accept:** edge E0, when `code_valid && code_ready`. After E0, `mem_addr` and `mem_rd_en` are valid.
- **Result:** `out_value` is captured and `out_valid` rises at edge E0+`MEM_DELAY`.
- **Handshake:** if `out_ready` is already high, the result is consumed at E0+`MEM_DELAY`+1. `code_ready` is high again in the following cycle.
- **Throughput:** one code per `MEM_DELAY+2` cycles.
- **Backpressure:** each cycle `out_ready` is low adds one cycle, with the output held stable.
- **Overlap:** a code presented while not in IDLE is not accepted. There is no overlap between fetches.

## Configuration
- **`OPERAND_DECODER_BANK_CHECK_EN` defined:**
  - A bank field `>= NUM_BANKS` is treated as an error fetch.
  - It still takes the full `MEM_DELAY` latency.
  - It returns `out_value = 0` with `out_error = 1`; `out_error` is valid with `out_valid` and is cleared on the handshake.
- **Macro undefined:**
  - The `out_error` port is absent.
  - An out-of-range bank returns bank 0 data.

## Test plan
- **Single fetch.** Setup: reset, `MEM_DELAY=2`, bank 2 word 5 = `32'hDEADBEEF`. Stimulus: present `inp_code=8'h85` with `out_ready=1`. Required response:
  - `mem_addr=4'h5` and `mem_rd_en=3'b100` after E0.
  - `out_valid` high at E0+2 with `out_value=32'hDEADBEEF`.
  - `code_ready` high again at E0+4.
- **Latency sweep.** Stimulus: `MEM_DELAY` = 1, 2 and 4. Required response: `out_valid` rises exactly `MEM_DELAY` edges after accept in each case.
- **Backpressure.** Stimulus: hold `out_ready=0` for 5 cycles, change `inp_code` during the stall. Required response:
  - `out_value` and `out_valid` stay stable.
  - `code_ready` stays low and no second accept occurs.
- **Back-to-back codes.** Stimulus: hold `code_valid` continuously with codes `8'h03`, then `8'h43`, with bank 0 and bank 1 word 3 loaded with distinct values. Required response: both bank 0 and bank 1 word 3 values return in order, accepted exactly 4 cycles apart.
- **Reset mid-WAIT.** Stimulus: assert `reset` one cycle after accept. Required response:
  - All outputs go to their reset values immediately.
  - `out_valid` never pulses for the dropped fetch.
- **Out-of-range bank (macro defined).** Stimulus: `inp_code=8'hC0`. Required response:
  - `mem_rd_en=0` after accept.
  - `out_value=0` and `out_error=1` at E0+2.

Source files
------------

// File: rtl/operand_fetch_decoder_if.sv
// Handshake and memory-bus bundle for operand_fetch_decoder.
// out_error exists only when OPERAND_DECODER_BANK_CHECK_EN is defined.
interface operand_fetch_decoder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CODE_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_BANKS  = 3
);
    logic                            code_valid;
    logic                            code_ready;
    logic [CODE_WIDTH-1:0]           inp_code;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic [NUM_BANKS-1:0]            mem_rd_en;
    logic [NUM_BANKS*DATA_WIDTH-1:0] mem_data_out;
    logic                            out_valid;
    logic                            out_ready;
    logic [DATA_WIDTH-1:0]           out_value;
`ifdef OPERAND_DECODER_BANK_CHECK_EN
    logic                            out_error;
`endif
    logic                            busy;

    // Decoder side: drives the memory bus and the result handshake.
    modport master (
        input  code_valid, inp_code, mem_data_out, out_ready,
        output code_ready, mem_addr, mem_rd_en, out_valid, out_value,
`ifdef OPERAND_DECODER_BANK_CHECK_EN
        output out_error,
`endif
        output busy
    );

    modport slave (
        output code_valid, inp_code, mem_data_out, out_ready,
        input  code_ready, mem_addr, mem_rd_en, out_valid, out_value,
`ifdef OPERAND_DECODER_BANK_CHECK_EN
        input  out_error,
`endif
        input  busy
    );
endinterface

// File: rtl/operand_fetch_decoder.sv
// Operand fetch decoder: splits a code into bank/address, reads a bank, returns the word.
// Define OPERAND_DECODER_BANK_CHECK_EN to flag out-of-range banks via out_error.
module operand_fetch_decoder #(
    parameter int DATA_WIDTH = 32,
    parameter int CODE_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_BANKS  = 3,
    parameter int SEL_WIDTH  = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1,
    parameter int MEM_DELAY  = 2
) (
    input logic                     clock,
    input logic                     reset,
    operand_fetch_decoder_if.master bus
);
    localparam int CNT_W = (MEM_DELAY > 1) ? $clog2(MEM_DELAY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       counter;
    logic [SEL_WIDTH-1:0]   bank_q;
    logic [SEL_WIDTH-1:0]   bank_in;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [NUM_BANKS-1:0]   rd_en_q;
    logic                   valid_q;
    logic [DATA_WIDTH-1:0]  value_q;
`ifdef OPERAND_DECODER_BANK_CHECK_EN
    logic                   error_q;
`endif

    function automatic logic bank_in_range(input logic [SEL_WIDTH-1:0] b);
        return int'(b) < NUM_BANKS;
    endfunction

    // Out-of-range indices match no bit, so they produce no strobe.
    function automatic logic [NUM_BANKS-1:0] bank_strobe(input logic [SEL_WIDTH-1:0] b);
        logic [NUM_BANKS-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_BANKS; i++)
            if (int'(b) == i) s[i] = 1'b1;
        return s;
    endfunction

    // Falls back to bank 0 when the index is out of range.
    function automatic logic [DATA_WIDTH-1:0] bank_word(
        input logic [SEL_WIDTH-1:0]            b,
        input logic [NUM_BANKS*DATA_WIDTH-1:0] data
    );
        logic [DATA_WIDTH-1:0] w;
        w = data[DATA_WIDTH-1:0];
        for (int i = 0; i < NUM_BANKS; i++)
            if (int'(b) == i) w = data[i*DATA_WIDTH +: DATA_WIDTH];
        return w;
    endfunction

    assign bank_in        = bus.inp_code[CODE_WIDTH-1 -: SEL_WIDTH];
    assign bus.code_ready = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_rd_en  = rd_en_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_value  = value_q;
`ifdef OPERAND_DECODER_BANK_CHECK_EN
    assign bus.out_error  = error_q;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.code_valid) state_nxt = WAIT;
            WAIT:    if (counter == '0) state_nxt = OUT;
            OUT:     if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            bank_q  <= '0;
            addr_q  <= '0;
            rd_en_q <= '0;
            valid_q <= 1'b0;
            value_q <= '0;
`ifdef OPERAND_DECODER_BANK_CHECK_EN
            error_q <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            rd_en_q <= '0;
            case (state)
                IDLE: begin
                    if (bus.code_valid) begin
                        addr_q  <= bus.inp_code[ADDR_WIDTH-1:0];
                        bank_q  <= bank_in;
                        rd_en_q <= bank_strobe(bank_in);
                        counter <= CNT_W'(MEM_DELAY - 1);
                    end
                end
                WAIT: begin
                    if (counter != '0) begin
                        counter <= counter - CNT_W'(1);
                    end else begin
                        valid_q <= 1'b1;
`ifdef OPERAND_DECODER_BANK_CHECK_EN
                        error_q <= !bank_in_range(bank_q);
                        value_q <= bank_in_range(bank_q) ? bank_word(bank_q, bus.mem_data_out) : '0;
`else
                        value_q <= bank_word(bank_q, bus.mem_data_out);
`endif
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
`ifdef OPERAND_DECODER_BANK_CHECK_EN
                        error_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    valid_q <= 1'b0;
`ifdef OPERAND_DECODER_BANK_CHECK_EN
                    error_q <= 1'b0;
`endif
                end
            endcase
        end
    end

`ifndef OPERAND_DECODER_BANK_CHECK_EN
    logic unused_range;
    assign unused_range = bank_in_range(bank_q);
`endif
endmodule
